// File: rtl/ep_wrr_arbiter_pkg.sv
// Shared types and constants for the endpoint TX weighted round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ep_wrr_arbiter_pkg;

  // Requester index; wide enough for the maximum of 8 requesters.
  typedef logic [2:0] idx_t;

  // One-hot FSM encoding.
  typedef enum logic [3:0] {
    ST_IDLE     = 4'b0001,
    ST_WAIT_DRV = 4'b0010,
    ST_OWNED    = 4'b0100,
    ST_RELEASE  = 4'b1000
  } arb_state_e;

  // stat_sel value that reads back the timeout counter.
  localparam logic [3:0] STAT_SEL_TMO = 4'hF;

  // Saturating 32-bit increment for statistics counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ep_wrr_arbiter_rr_pick.sv
// Rotating first-one finder: first set bit of mask searching upward from start, wrapping.
// Latency: combinational.
// Backpressure: none; found=0 when mask is empty.
module rr_pick
  import ep_wrr_arbiter_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0] mask,
  input  idx_t         start,
  output idx_t         idx,
  output logic         found
);

  logic [7:0] w_mask8;
  logic [3:0] w_j;

  assign w_mask8 = 8'(mask);

  // Walk N positions from start, wrapping at N; keep the first hit.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    w_j   = '0;
    for (int k = 0; k < N; k++) begin
      w_j = {1'b0, start} + 4'(k);
      if (w_j >= 4'(N)) w_j = w_j - 4'(N);
      if (!found && w_mask8[w_j[2:0]]) begin
        found = 1'b1;
        idx   = w_j[2:0];
      end
    end
  end

endmodule

// File: rtl/ep_wrr_arbiter.sv
// Weighted round-robin arbiter for the endpoint TX path; optional statistics under EP_ARB_STATS_EN.
// Latency: turn pulses on the edge after req is sampled in IDLE; stat_data has one-cycle read latency.
// Backpressure: any driven bit holds off new grants; an untaken grant is revoked after GRANT_TMO cycles.
module ep_wrr_arbiter
  import ep_wrr_arbiter_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int WW        = 4,
  parameter int GRANT_TMO = 16,
  parameter int TW        = 5
) (
  input  logic             trn_clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  driven,
  input  logic [NREQ*WW-1:0] weight,
  output logic [NREQ-1:0]  turn,
  output logic             busy,
  output logic [2:0]       owner,
  output logic             tmo_err,
  input  logic [3:0]       stat_sel,
  output logic [31:0]      stat_data
);

  arb_state_e r_state, w_state_nxt;
  logic [NREQ-1:0] r_turn, w_turn_nxt;
  logic            r_busy, w_busy_nxt;
  idx_t            r_owner, w_owner_nxt;
  logic            r_tmo_err, w_tmo_err_nxt;
  idx_t            r_ptr, w_ptr_nxt;
  logic [WW-1:0]   r_cred, w_cred_nxt;
  logic [TW-1:0]   r_tmo_cnt, w_tmo_cnt_nxt;

  logic            w_grant;
  idx_t            w_grant_idx;
  logic [NREQ-1:0] w_elig;
  logic [7:0]      w_elig8;
  logic [7:0]      w_drv8;
  logic [WW-1:0]   w_wt [8];
  idx_t            w_start;
  idx_t            w_pick_idx;
  logic            w_pick_found;

  // Per-requester weights padded to 8 slots so a 3-bit index is always in range.
  for (genvar gi = 0; gi < 8; gi++) begin : g_wt
    if (gi < NREQ) begin : g_on
      assign w_wt[gi] = weight[gi*WW +: WW];
    end else begin : g_off
      assign w_wt[gi] = '0;
    end
  end

  // A zero weight masks the requester out entirely.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_elig
    assign w_elig[gi] = req[gi] && (w_wt[gi] != '0);
  end

  assign w_elig8 = 8'(w_elig);
  assign w_drv8  = 8'(driven);
  assign w_start = (r_ptr == idx_t'(NREQ-1)) ? idx_t'(0) : r_ptr + idx_t'(1);

  rr_pick #(.N(NREQ)) u_pick (
    .mask  (w_elig),
    .start (w_start),
    .idx   (w_pick_idx),
    .found (w_pick_found)
  );

  // Next-state and next-register values for the grant FSM.
  always_comb begin
    w_state_nxt   = r_state;
    w_turn_nxt    = '0;
    w_busy_nxt    = r_busy;
    w_owner_nxt   = r_owner;
    w_tmo_err_nxt = 1'b0;
    w_ptr_nxt     = r_ptr;
    w_cred_nxt    = r_cred;
    w_tmo_cnt_nxt = r_tmo_cnt;
    w_grant       = 1'b0;
    w_grant_idx   = '0;
    case (r_state)
      ST_IDLE: begin
        if (driven == '0 && w_pick_found) begin
          w_grant = 1'b1;
          if (w_elig8[r_ptr] && r_cred != '0) begin
            // Current holder still has credit left: stay on it.
            w_grant_idx = r_ptr;
            w_cred_nxt  = r_cred - WW'(1);
          end else begin
            // Move to the next eligible requester and reload its share.
            w_grant_idx = w_pick_idx;
            w_ptr_nxt   = w_pick_idx;
            w_cred_nxt  = w_wt[w_pick_idx] - WW'(1);
          end
          for (int i = 0; i < NREQ; i++) w_turn_nxt[i] = (w_grant_idx == idx_t'(i));
          w_owner_nxt   = w_grant_idx;
          w_busy_nxt    = 1'b1;
          w_tmo_cnt_nxt = '0;
          w_state_nxt   = ST_WAIT_DRV;
        end
      end
      ST_WAIT_DRV: begin
        w_tmo_cnt_nxt = r_tmo_cnt + TW'(1);
        if (w_drv8[r_owner]) begin
          w_state_nxt = ST_OWNED;
        end else if (r_tmo_cnt == TW'(GRANT_TMO-1)) begin
          // Grant not taken in time: revoke and forfeit remaining credit.
          w_tmo_err_nxt = 1'b1;
          w_cred_nxt    = '0;
          w_state_nxt   = ST_RELEASE;
        end
      end
      ST_OWNED: begin
        if (!w_drv8[r_owner]) w_state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge trn_clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Grant, credit and timeout registers.
  always_ff @(posedge trn_clk or posedge reset) begin
    if (reset) begin
      r_turn    <= '0;
      r_busy    <= 1'b0;
      r_owner   <= '0;
      r_tmo_err <= 1'b0;
      r_ptr     <= idx_t'(NREQ-1);
      r_cred    <= '0;
      r_tmo_cnt <= '0;
    end else begin
      r_turn    <= w_turn_nxt;
      r_busy    <= w_busy_nxt;
      r_owner   <= w_owner_nxt;
      r_tmo_err <= w_tmo_err_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cred    <= w_cred_nxt;
      r_tmo_cnt <= w_tmo_cnt_nxt;
    end
  end

  assign turn    = r_turn;
  assign busy    = r_busy;
  assign owner   = r_owner;
  assign tmo_err = r_tmo_err;

`ifdef EP_ARB_STATS_EN
  logic [31:0] r_grants [NREQ];
  logic [31:0] r_tmo_total;
  logic [31:0] r_stat_data;
  logic [31:0] w_stat_mux;

  // Saturating grant and timeout counters.
  always_ff @(posedge trn_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) r_grants[i] <= '0;
      r_tmo_total <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_grant && w_grant_idx == idx_t'(i)) r_grants[i] <= sat_inc(r_grants[i]);
      end
      if (w_tmo_err_nxt) r_tmo_total <= sat_inc(r_tmo_total);
    end
  end

  // Readback select; unmapped selects read zero.
  always_comb begin
    w_stat_mux = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (stat_sel == 4'(i)) w_stat_mux = r_grants[i];
    end
    if (stat_sel == STAT_SEL_TMO) w_stat_mux = r_tmo_total;
  end

  // Registered readback.
  always_ff @(posedge trn_clk or posedge reset) begin
    if (reset) r_stat_data <= '0;
    else       r_stat_data <= w_stat_mux;
  end

  assign stat_data = r_stat_data;
`else
  logic w_unused_stat_sel;
  assign w_unused_stat_sel = ^stat_sel;
  assign stat_data = '0;
`endif

endmodule
